// File: rtl/eth_rx_audio_if.sv
// Audio-side output bundle of the Ethernet audio receiver.
// The receiver drives it through master; the audio/PDM path reads it through slave.
interface eth_rx_audio_if;
  logic [15:0] sample;
  logic        sample_stb;
  logic        rx_active;
  logic        frame_done;
  logic        frame_ok;

  modport master (output sample, sample_stb, rx_active, frame_done, frame_ok);
  modport slave  (input  sample, sample_stb, rx_active, frame_done, frame_ok);
endinterface

// File: rtl/eth_rx_audio.sv
// 10BASE-T audio receiver: Manchester bit recovery, preamble/SFD hunt, header skip,
// big-endian 16-bit sample packing and CRC-32 frame check reported at line idle.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WAIT_IDLE | after reset, wait for the line to go quiet before hunting
// HUNT      | look for the SFD byte 8'hD5 in the recovered bit stream
// HDR       | count and CRC the Ethernet/IP/UDP header bytes
// PAYLOAD   | CRC payload bytes, delay them 4 bytes, pack into samples
// END       | one cycle: frame_done pulse with frame_ok verdict
module eth_rx_audio #(
  parameter int CLKS_PER_BIT = 8,
  parameter int HDR_BYTES    = 42
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           rx_eth,
  eth_rx_audio_if.master aud
);

  localparam int          TW        = $clog2(2*CLKS_PER_BIT+1);
  localparam logic [TW-1:0] T_MID   = TW'(3*CLKS_PER_BIT/4);
  localparam logic [TW-1:0] T_IDLE  = TW'(2*CLKS_PER_BIT);
  localparam logic [TW-1:0] T_IDLE1 = TW'(2*CLKS_PER_BIT-1);
  localparam logic [31:0] CRC_POLY  = 32'hEDB88320;
  localparam logic [31:0] CRC_RES   = 32'hDEBB20E3;
  localparam logic [10:0] HDR_LAST  = 11'(HDR_BYTES-1);
  localparam logic [10:0] MIN_LEN   = 11'(HDR_BYTES+4);
  localparam logic [7:0]  SFD       = 8'hD5;

  typedef enum logic [2:0] {WAIT_IDLE, HUNT, HDR, PAYLOAD, END} state_t;

  state_t         state, state_n;
  logic [1:0]     sync;
  logic           line_edge, bit_stb, bit_val, idle_evt;
  logic [TW-1:0]  t, idle_cnt;
  logic [7:0]     sr, sr_next;
  logic           sfd_hit, end_hit, in_frame;
  logic [2:0]     bit_cnt;
  logic           byte_stb;
  logic [10:0]    byte_cnt;
  logic [31:0]    crc;
  logic [3:0][7:0] dl;
  logic [2:0]     dl_cnt;
  logic           pk_odd;
  logic [7:0]     pk_hi;
  logic [15:0]    sample_q;
  logic           sample_stb_q, rx_active_q, frame_ok_q;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    return r;
  endfunction

  assign line_edge = sync[1] ^ sync[0];
  assign bit_stb   = line_edge && (t >= T_MID);
  assign bit_val   = sync[0];
  assign idle_evt  = !line_edge && (idle_cnt == T_IDLE1);
  assign sr_next   = {bit_val, sr[7:1]};
  assign in_frame  = (state == HDR) || (state == PAYLOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync     <= 2'b00;
      t        <= T_IDLE;
      idle_cnt <= '0;
      sr       <= 8'h00;
    end else begin
      sync <= {sync[0], rx_eth};
      // t starts saturated so the very first edge is taken as a mid-bit edge
      if (bit_stb)          t <= '0;
      else if (t != T_IDLE) t <= t + TW'(1);
      if (line_edge)                  idle_cnt <= '0;
      else if (idle_cnt != T_IDLE)    idle_cnt <= idle_cnt + TW'(1);
      if (bit_stb) sr <= sr_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    sfd_hit = 1'b0;
    end_hit = 1'b0;
    case (state)
      WAIT_IDLE: if (idle_evt) state_n = HUNT;
      HUNT: begin
        if (bit_stb && (sr_next == SFD)) begin
          state_n = HDR;
          sfd_hit = 1'b1;
        end
      end
      HDR: begin
        if (idle_evt) begin
          state_n = END;
          end_hit = 1'b1;
        end else if (byte_stb && (byte_cnt == HDR_LAST)) begin
          state_n = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (idle_evt) begin
          state_n = END;
          end_hit = 1'b1;
        end
      end
      END:     state_n = HUNT;
      default: state_n = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt      <= 3'd0;
      byte_stb     <= 1'b0;
      byte_cnt     <= 11'd0;
      crc          <= 32'hFFFFFFFF;
      dl           <= '0;
      dl_cnt       <= 3'd0;
      pk_odd       <= 1'b0;
      pk_hi        <= 8'h00;
      sample_q     <= 16'h0000;
      sample_stb_q <= 1'b0;
      rx_active_q  <= 1'b0;
      frame_ok_q   <= 1'b0;
    end else begin
      byte_stb     <= 1'b0;
      sample_stb_q <= 1'b0;
      if (sfd_hit) begin
        bit_cnt     <= 3'd0;
        byte_cnt    <= 11'd0;
        crc         <= 32'hFFFFFFFF;
        dl_cnt      <= 3'd0;
        pk_odd      <= 1'b0;
        rx_active_q <= 1'b1;
      end else if (in_frame && bit_stb) begin
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) byte_stb <= 1'b1;
      end

      if (in_frame && byte_stb) begin
        crc <= crc_byte(crc, sr);
        if (byte_cnt != 11'h7FF) byte_cnt <= byte_cnt + 11'd1;
        if (state == PAYLOAD) begin
          dl <= {dl[2:0], sr};
          if (dl_cnt != 3'd4) begin
            dl_cnt <= dl_cnt + 3'd1;
          end else begin
            // dl[3] is the byte falling out of the 4-byte FCS guard
            if (!pk_odd) begin
              pk_hi <= dl[3];
            end else begin
              sample_q     <= {pk_hi, dl[3]};
              sample_stb_q <= 1'b1;
            end
            pk_odd <= !pk_odd;
          end
        end
      end

      if (end_hit) begin
        rx_active_q <= 1'b0;
        frame_ok_q  <= (state == PAYLOAD) && (crc == CRC_RES) &&
                       (bit_cnt == 3'd0) && (byte_cnt >= MIN_LEN);
      end
    end
  end

  assign aud.sample     = sample_q;
  assign aud.sample_stb = sample_stb_q;
  assign aud.rx_active  = rx_active_q;
  assign aud.frame_done = (state == END);
  assign aud.frame_ok   = frame_ok_q;

endmodule

// File: tb/tb_eth_rx_audio.sv
// Directed bench for eth_rx_audio: builds Manchester frames with a computed FCS
// and checks samples and frame status against hand-derived expectations.
`timescale 1ns/100ps
module tb_eth_rx_audio;

  localparam int HALF_NS = 40;
  localparam logic [31:0] POLY = 32'hEDB88320;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic rx_eth = 1'b1;

  eth_rx_audio_if aud_if();

  eth_rx_audio #(.CLKS_PER_BIT(8), .HDR_BYTES(42)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx_eth (rx_eth),
    .aud    (aud_if)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int n_samp = 0, n_done = 0, n_ok = 0, n_ovl = 0;
  logic last_ok = 1'b0;
  logic [15:0] samp_q[$];
  logic [7:0]  pl[$];
  bit jit_en = 1'b0;
  int prev_off = 0;
  int b_samp, b_done, b_ok;

  always @(negedge clk) begin
    if (aud_if.sample_stb) begin
      n_samp <= n_samp + 1;
      samp_q.push_back(aud_if.sample);
    end
    if (aud_if.frame_done) begin
      n_done  <= n_done + 1;
      last_ok <= aud_if.frame_ok;
      if (aud_if.frame_ok) n_ok <= n_ok + 1;
    end
    if (aud_if.sample_stb && aud_if.frame_done) n_ovl <= n_ovl + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] samp_at(input int i);
    if (i < samp_q.size()) return samp_q[i];
    return 16'h0000;
  endfunction

  // each edge lands within +/-4 ns of its ideal time when jitter is on
  task automatic half(input logic lvl);
    int off, dur;
    rx_eth = lvl;
    off = jit_en ? (int'($urandom_range(8)) - 4) : 0;
    dur = HALF_NS + off - prev_off;
    prev_off = off;
    #(dur);
  endtask

  task automatic send_bit(input logic b);
    half(~b);
    half(b);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic send_frame(input int n_hdr, input bit fcs, input int flip, input int dribble);
    logic [7:0]  bytes[$];
    logic [31:0] c;
    logic fb;
    for (int i = 0; i < n_hdr; i++) bytes.push_back(8'(i*7 + 3));
    foreach (pl[i]) bytes.push_back(pl[i]);
    c = 32'hFFFFFFFF;
    foreach (bytes[j])
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ bytes[j][k];
        c  = c >> 1;
        if (fb) c = c ^ POLY;
      end
    if (fcs) begin
      c = ~c;
      bytes.push_back(c[7:0]);
      bytes.push_back(c[15:8]);
      bytes.push_back(c[23:16]);
      bytes.push_back(c[31:24]);
    end
    if (flip >= 0) bytes[n_hdr + flip] = bytes[n_hdr + flip] ^ 8'h01;
    prev_off = 0;
    for (int i = 0; i < 7; i++) send_byte(8'h55);
    send_byte(8'hD5);
    foreach (bytes[j]) send_byte(bytes[j]);
    for (int i = 0; i < dribble; i++) send_bit(i[0]);
  endtask

  task automatic snap();
    b_samp = n_samp;
    b_done = n_done;
    b_ok   = n_ok;
  endtask

  task automatic settle();
    repeat (60) @(posedge clk);
  endtask

  initial begin
    #50;
    chk("rst_sample",     32'(aud_if.sample),     32'h0);
    chk("rst_sample_stb", 32'(aud_if.sample_stb), 32'h0);
    chk("rst_rx_active",  32'(aud_if.rx_active),  32'h0);
    chk("rst_frame_done", 32'(aud_if.frame_done), 32'h0);
    chk("rst_frame_ok",   32'(aud_if.frame_ok),   32'h0);
    #53 rst_n = 1'b1;
    repeat (30) @(posedge clk);

    // 1: valid frame
    pl = '{8'h12, 8'h34, 8'hAB, 8'hCD};
    snap();
    fork
      send_frame(42, 1'b1, -1, 0);
      begin #8000; chk("t1_active", 32'(aud_if.rx_active), 32'h1); end
    join
    settle();
    chk("t1_nsamp", 32'(n_samp - b_samp), 32'd2);
    chk("t1_s0",    32'(samp_at(b_samp)),     32'h1234);
    chk("t1_s1",    32'(samp_at(b_samp + 1)), 32'hABCD);
    chk("t1_ndone", 32'(n_done - b_done), 32'd1);
    chk("t1_ok",    32'(last_ok), 32'h1);
    chk("t1_idle_active", 32'(aud_if.rx_active), 32'h0);

    // 2: bit 0 of payload byte 0x34 flipped
    snap();
    send_frame(42, 1'b1, 1, 0);
    settle();
    chk("t2_nsamp", 32'(n_samp - b_samp), 32'd2);
    chk("t2_s0",    32'(samp_at(b_samp)),     32'h1235);
    chk("t2_s1",    32'(samp_at(b_samp + 1)), 32'hABCD);
    chk("t2_ndone", 32'(n_done - b_done), 32'd1);
    chk("t2_ok",    32'(last_ok), 32'h0);

    // 3: frame cut inside the header
    pl = {};
    snap();
    send_frame(20, 1'b0, -1, 0);
    settle();
    chk("t3_nsamp", 32'(n_samp - b_samp), 32'd0);
    chk("t3_ndone", 32'(n_done - b_done), 32'd1);
    chk("t3_ok",    32'(last_ok), 32'h0);

    // 4: odd payload, first with dribble bits, then clean
    pl = '{8'h12, 8'h34, 8'h56};
    snap();
    send_frame(42, 1'b1, -1, 3);
    settle();
    chk("t4d_nsamp", 32'(n_samp - b_samp), 32'd1);
    chk("t4d_ndone", 32'(n_done - b_done), 32'd1);
    chk("t4d_ok",    32'(last_ok), 32'h0);
    snap();
    send_frame(42, 1'b1, -1, 0);
    settle();
    chk("t4_nsamp", 32'(n_samp - b_samp), 32'd1);
    chk("t4_s0",    32'(samp_at(b_samp)), 32'h1234);
    chk("t4_ok",    32'(last_ok), 32'h1);

    // 5: reset mid-payload, released while the frame is still on the line
    pl = '{8'h12, 8'h34, 8'hAB, 8'hCD};
    snap();
    fork
      send_frame(42, 1'b1, -1, 0);
      begin
        #33000;
        chk("t5_pre_active", 32'(aud_if.rx_active), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_sample", 32'(aud_if.sample),    32'h0);
        chk("t5_rst_active", 32'(aud_if.rx_active), 32'h0);
        chk("t5_rst_ok",     32'(aud_if.frame_ok),  32'h0);
        #300 rst_n = 1'b1;
      end
    join
    settle();
    chk("t5_nsamp", 32'(n_samp - b_samp), 32'd0);
    chk("t5_ndone", 32'(n_done - b_done), 32'd0);
    snap();
    send_frame(42, 1'b1, -1, 0);
    settle();
    chk("t5b_nsamp", 32'(n_samp - b_samp), 32'd2);
    chk("t5b_s1",    32'(samp_at(b_samp + 1)), 32'hABCD);
    chk("t5b_ndone", 32'(n_done - b_done), 32'd1);
    chk("t5b_ok",    32'(last_ok), 32'h1);

    // 6: jittered edges, then back-to-back frames with a 2-bit idle gap
    jit_en = 1'b1;
    snap();
    send_frame(42, 1'b1, -1, 0);
    settle();
    chk("t6_nsamp", 32'(n_samp - b_samp), 32'd2);
    chk("t6_s0",    32'(samp_at(b_samp)),     32'h1234);
    chk("t6_s1",    32'(samp_at(b_samp + 1)), 32'hABCD);
    chk("t6_ok",    32'(last_ok), 32'h1);
    snap();
    send_frame(42, 1'b1, -1, 0);
    #(4*HALF_NS);
    send_frame(42, 1'b1, -1, 0);
    settle();
    chk("t6bb_ndone", 32'(n_done - b_done), 32'd2);
    chk("t6bb_nok",   32'(n_ok - b_ok),     32'd2);
    chk("t6bb_nsamp", 32'(n_samp - b_samp), 32'd4);
    chk("t6bb_s3",    32'(samp_at(b_samp + 3)), 32'hABCD);

    chk("stb_done_overlap", 32'(n_ovl), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
